// File: rtl/regfile_writeback_queue.sv
// Writeback queue feeding the 16x16 register file write port.
// Buffers ALU/load results in a small FIFO, drains one entry per cycle onto
// Rd/RW/wr, and exposes pending-write hazards plus youngest-data forwarding
// for the two read selects so readers never observe stale register values.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [DW-1:0]              in_data,
  input  logic                       wb_stall,
  input  logic                       flush,
  output logic [AW-1:0]              Rd,
  output logic [DW-1:0]              RW,
  output logic                       wr,
  input  logic [AW-1:0]              Rs,
  input  logic [AW-1:0]              Rt,
  output logic                       Rs_pending,
  output logic                       Rt_pending,
  output logic [DW-1:0]              Rs_fwd,
  output logic [DW-1:0]              Rt_fwd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Queue control state.
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Queue payload storage.
  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          push;
  logic          pop;
  logic [PW-1:0] scan_idx;

  assign count = count_q;

  // Handshake and drain port, driven straight from the head entry.
  always_comb begin
    in_ready = (count_q != CW'(DEPTH));
    push     = in_valid & in_ready & ~flush;
    wr       = (count_q != '0) & ~wb_stall & ~flush;
    pop      = wr;
    Rd       = (count_q != '0) ? rd_q[head_q]   : '0;
    RW       = (count_q != '0) ? data_q[head_q] : '0;
  end

  // Next-state for pointers, occupancy and entry valid bits.
  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register, cleared asynchronously so in-flight entries vanish.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload write at the tail on an accepted push.
  // NOTE: payload storage is deliberately not reset; valid bits and count gate every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= in_rd;
      data_q[tail_q] <= in_data;
    end
  end

  // Hazard search from oldest to youngest; the last hit is the youngest data.
  always_comb begin
    Rs_pending = 1'b0;
    Rt_pending = 1'b0;
    Rs_fwd     = '0;
    Rt_fwd     = '0;
    scan_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (rd_q[scan_idx] == Rs)) begin
        Rs_pending = 1'b1;
        Rs_fwd     = data_q[scan_idx];
      end
      if (valid_q[scan_idx] && (rd_q[scan_idx] == Rt)) begin
        Rt_pending = 1'b1;
        Rt_fwd     = data_q[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [15:0] in_data;
  logic        wb_stall;
  logic        flush;
  logic [3:0]  Rd;
  logic [15:0] RW;
  logic        wr;
  logic [3:0]  Rs;
  logic [3:0]  Rt;
  logic        Rs_pending;
  logic        Rt_pending;
  logic [15:0] Rs_fwd;
  logic [15:0] Rt_fwd;
  logic [2:0]  count;

  int   nvec = 0;
  int   nerr = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .wb_stall   (wb_stall),
    .flush      (flush),
    .Rd         (Rd),
    .RW         (RW),
    .wr         (wr),
    .Rs         (Rs),
    .Rt         (Rt),
    .Rs_pending (Rs_pending),
    .Rt_pending (Rt_pending),
    .Rs_fwd     (Rs_fwd),
    .Rt_fwd     (Rt_fwd),
    .count      (count)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference search: youngest queued entry targeting sel.
  function automatic void mfind(input logic [3:0] sel, output logic p, output logic [15:0] d);
    p = 1'b0;
    d = 16'h0;
    foreach (q[i]) begin
      if (q[i].rd == sel) begin
        p = 1'b1;
        d = q[i].data;
      end
    end
  endfunction

  task automatic check_all();
    logic        sp, tp;
    logic [15:0] sd, td;
    int          sz;
    sz = q.size();
    mfind(Rs, sp, sd);
    mfind(Rt, tp, td);
    chk("count",      count,      sz);
    chk("in_ready",   in_ready,   (sz != DEPTH));
    chk("wr",         wr,         (sz != 0) && !wb_stall && !flush);
    chk("Rd",         Rd,         (sz != 0) ? q[0].rd   : 4'h0);
    chk("RW",         RW,         (sz != 0) ? q[0].data : 16'h0);
    chk("Rs_pending", Rs_pending, sp);
    chk("Rs_fwd",     Rs_fwd,     sd);
    chk("Rt_pending", Rt_pending, tp);
    chk("Rt_fwd",     Rt_fwd,     td);
  endtask

  // One clock: check mid-cycle, clock edge, then advance the model.
  task automatic step();
    logic full, do_pop;
    #3;
    check_all();
    full   = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && !wb_stall && !flush;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (in_valid && !full) q.push_back({in_rd, in_data});
    end
    #1;
  endtask

  task automatic drv(input logic v, input logic [3:0] rd, input logic [15:0] d,
                     input logic st, input logic fl);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wb_stall = st;
    flush    = fl;
  endtask

  initial begin
    logic [3:0] exp_rd [4];
    exp_rd[0] = 4'h3; exp_rd[1] = 4'h9; exp_rd[2] = 4'hA; exp_rd[3] = 4'h9;

    // Reset and release.
    rst = 1'b1;
    Rs  = 4'h0;
    Rt  = 4'h0;
    drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;
    #1;
    chk("rst_wr",       wr,       1'b0);
    chk("rst_count",    count,    3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_Rd",       Rd,       4'h0);
    chk("rst_RW",       RW,       16'h0);
    step();

    // Single push into empty: written one cycle later, then empty.
    drv(1'b1, 4'hF, 16'h1450, 1'b0, 1'b0);
    step();
    drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("lat_wr", wr, 1'b1);
    chk("lat_Rd", Rd, 4'hF);
    chk("lat_RW", RW, 16'h1450);
    step();
    chk("lat_empty", count, 3'd0);
    step();

    // Stalled fill, hazard lookups, ignored push when full.
    Rs = 4'h9;
    Rt = 4'h2;
    drv(1'b1, 4'h3, 16'h2150, 1'b1, 1'b0); step();
    drv(1'b1, 4'h9, 16'h0512, 1'b1, 1'b0); step();
    drv(1'b1, 4'hA, 16'h0512, 1'b1, 1'b0); step();
    drv(1'b1, 4'h9, 16'h0777, 1'b1, 1'b0); step();
    drv(1'b1, 4'h5, 16'hDEAD, 1'b1, 1'b0); step();
    drv(1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
    #1;
    chk("full_count",   count,      3'd4);
    chk("full_ready",   in_ready,   1'b0);
    chk("full_Rs_pend", Rs_pending, 1'b1);
    chk("full_Rs_fwd",  Rs_fwd,     16'h0777);
    chk("full_Rt_pend", Rt_pending, 1'b0);
    chk("full_Rt_fwd",  Rt_fwd,     16'h0);
    step();

    // Release stall: four back-to-back writes in arrival order.
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_wr", wr, 1'b1);
      chk("drain_Rd", Rd, exp_rd[i]);
      step();
    end
    chk("drain_empty", count, 3'd0);
    step();

    // Flush at count=2 beats a same-cycle push.
    drv(1'b1, 4'h1, 16'h1111, 1'b1, 1'b0); step();
    drv(1'b1, 4'h2, 16'h2222, 1'b1, 1'b0); step();
    drv(1'b1, 4'h4, 16'h4444, 1'b0, 1'b1);
    #1;
    chk("flush_wr_now", wr, 1'b0);
    step();
    drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("flush_count", count, 3'd0);
    chk("flush_wr",    wr,    1'b0);
    step();

    // Async reset in the middle of a drain at count=3.
    drv(1'b1, 4'h6, 16'h6001, 1'b1, 1'b0); step();
    drv(1'b1, 4'h7, 16'h7002, 1'b1, 1'b0); step();
    drv(1'b1, 4'h8, 16'h8003, 1'b1, 1'b0); step();
    drv(1'b1, 4'hB, 16'hB004, 1'b0, 1'b0); step();
    chk("pre_rst_count", count, 3'd3);
    #1 rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_wr",    wr,    1'b0);
    chk("mid_rst_count", count, 3'd0);
    check_all();
    #1 rst = 1'b0;
    drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    step();

    // Continuous push+pop to wrap the pointers several times.
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 4'(i), 16'(16'hC000 + i), 1'b0, 1'b0);
      Rs = 4'(i);
      Rt = 4'(i - 1);
      step();
    end
    drv(1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
    step();

    // Random traffic with a narrow register range to provoke hazards.
    for (int c = 0; c < 500; c++) begin
      drv(($urandom % 10) < 7, 4'($urandom_range(0, 7)), 16'($urandom),
          ($urandom % 10) < 3, ($urandom % 25) == 0);
      Rs = 4'($urandom_range(0, 7));
      Rt = 4'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
